// File: rtl/radio_pkg.sv
// radio_pkg: shared types and helpers for the FM audio path.
//   SAMPLE_W  - width of one signed audio/phase sample
//   sample_t  - signed SAMPLE_W-bit sample type
//   saturate  - clamps a wide signed value to the sample_t range
package radio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic sample_t saturate(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return sample_t'(v);
    end
  endfunction

endpackage

// File: rtl/deemph_iir.sv
// deemph_iir: 1-pole de-emphasis low-pass, alpha = 2**-DEEMPH_SHIFT.
// The state y carries DEEMPH_SHIFT fractional bits.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, clears y
//   in_valid   in   advance the filter by one step using in_sample
//   in_sample  in   new input sample (sample_t)
//   out_sample out  saturated output for the step being taken this cycle
//                   (combinational from y and in_sample, meaningful when
//                   in_valid = 1 so the caller can register it alongside y)
module deemph_iir
  import radio_pkg::*;
#(
  parameter int DEEMPH_SHIFT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  sample_t in_sample,
  output sample_t out_sample
);

  localparam int Y_W = SAMPLE_W + DEEMPH_SHIFT;

  logic signed [Y_W-1:0] y;
  // One extra bit: target - y spans twice the sample range.
  logic signed [Y_W:0]   target;
  logic signed [Y_W:0]   diff;
  logic signed [Y_W:0]   step;
  logic signed [Y_W:0]   y_next_w;

  always_comb begin
    target     = {{(DEEMPH_SHIFT + 1){in_sample[SAMPLE_W-1]}}, in_sample};
    target     = target <<< DEEMPH_SHIFT;
    diff       = target - {y[Y_W-1], y};
    step       = diff >>> DEEMPH_SHIFT;
    y_next_w   = {y[Y_W-1], y} + step;
    out_sample = saturate(32'(y_next_w >>> DEEMPH_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (in_valid) begin
      y <= y_next_w[Y_W-1:0];
    end
  end

endmodule

// File: rtl/audio_decimator.sv
// audio_decimator: integrate-and-dump decimator (factor 2**DECIM_LOG2)
// followed by a 1-pole de-emphasis filter, AXI-Stream in and out.
//   s00_axis_aclk     in   clock, rising edge
//   s00_axis_aresetn  in   synchronous reset, ACTIVE-HIGH despite the name
//   s00_axis_tvalid   in   input sample valid
//   s00_axis_tlast    in   end of burst; closes the current window early
//   s00_axis_tdata    in   [15:0] signed sample, upper bits ignored
//   s00_axis_tstrb    in   ignored
//   s00_axis_tready   out  input accept
//   m00_axis_tready   in   downstream accept
//   m00_axis_tvalid   out  output sample valid
//   m00_axis_tlast    out  window was closed by input tlast
//   m00_axis_tdata    out  {zeros, audio[15:0]}
//   m00_axis_tstrb    out  all ones while tvalid
module audio_decimator
  import radio_pkg::*;
#(
  parameter int c_s00_axis_tdata_width = 32,
  parameter int c_m00_axis_tdata_width = 32,
  parameter int DECIM_LOG2             = 3,
  parameter int DEEMPH_SHIFT           = 4
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [c_s00_axis_tdata_width-1:0]     s00_axis_tdata,
  input  logic [(c_s00_axis_tdata_width/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [c_m00_axis_tdata_width-1:0]     m00_axis_tdata,
  output logic [(c_m00_axis_tdata_width/8)-1:0] m00_axis_tstrb
);

  localparam int DECIM = 1 << DECIM_LOG2;
  // Counter needs at least one bit even when there is no decimation.
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

  logic                    clk;
  logic                    rst;
  logic                    accept;
  logic                    dump;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  sample_t                 x;
  sample_t                 avg;
  sample_t                 audio;
  logic                    unused_inputs;

  assign clk           = s00_axis_aclk;
  assign rst           = s00_axis_aresetn;
  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[c_s00_axis_tdata_width-1:SAMPLE_W]};

  assign s00_axis_tready = ~rst & (~m00_axis_tvalid | m00_axis_tready);
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  always_comb begin
    x    = s00_axis_tdata[SAMPLE_W-1:0];
    dump = (cnt == CNT_W'(DECIM - 1)) | s00_axis_tlast;
    // A full window of extreme samples fits exactly in ACC_W bits.
    sum  = acc + ACC_W'(x);
    avg  = sample_t'(sum >>> DECIM_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (dump) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  deemph_iir #(
    .DEEMPH_SHIFT(DEEMPH_SHIFT)
  ) u_deemph (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept & dump),
    .in_sample (avg),
    .out_sample(audio)
  );

  // Single output register; s00_axis_tready already guarantees it is
  // empty or draining whenever a dump beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
    end else if (accept && dump) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= s00_axis_tlast;
      m00_axis_tdata  <= {{(c_m00_axis_tdata_width - SAMPLE_W){1'b0}}, audio};
      m00_axis_tstrb  <= '1;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tstrb  <= '0;
    end
  end

endmodule

// File: tb/tb_audio_decimator.sv
module tb_audio_decimator;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        m_tready;

  logic        s_tready0, m0_tvalid, m0_tlast;
  logic [31:0] m0_tdata;
  logic [3:0]  m0_tstrb;
  logic        s_tready4, m4_tvalid, m4_tlast;
  logic [31:0] m4_tdata;
  logic [3:0]  m4_tstrb;

  int tests = 0;
  int fails = 0;

  logic [36:0] q0[$];
  logic [36:0] q4[$];

  audio_decimator #(
    .c_s00_axis_tdata_width(32),
    .c_m00_axis_tdata_width(32),
    .DECIM_LOG2(3),
    .DEEMPH_SHIFT(0)
  ) dut0 (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tready (s_tready0),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m0_tvalid),
    .m00_axis_tlast  (m0_tlast),
    .m00_axis_tdata  (m0_tdata),
    .m00_axis_tstrb  (m0_tstrb)
  );

  audio_decimator #(
    .c_s00_axis_tdata_width(32),
    .c_m00_axis_tdata_width(32),
    .DECIM_LOG2(3),
    .DEEMPH_SHIFT(4)
  ) dut4 (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tready (s_tready4),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m4_tvalid),
    .m00_axis_tlast  (m4_tlast),
    .m00_axis_tdata  (m4_tdata),
    .m00_axis_tstrb  (m4_tstrb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Record each output beat the cycle before its handshake edge.
  always @(negedge clk) begin
    if (m0_tvalid && m_tready) q0.push_back({m0_tstrb, m0_tlast, m0_tdata});
    if (m4_tvalid && m_tready) q4.push_back({m4_tstrb, m4_tlast, m4_tdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop0(input string tag, input logic [31:0] d, input logic l);
    logic [36:0] got;
    got = (q0.size() == 0) ? '1 : q0.pop_front();
    chk(tag, 64'(got), 64'({4'hF, l, d}));
  endtask

  task automatic pop4(input string tag, input logic [31:0] d, input logic l);
    logic [36:0] got;
    got = (q4.size() == 0) ? '1 : q4.pop_front();
    chk(tag, 64'(got), 64'({4'hF, l, d}));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send(input int x, input bit last);
    int  n;
    bit  done;
    n        = 0;
    done     = 1'b0;
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tdata  = {16'hA5A5, 16'(x)};
    while (!done) begin
      @(negedge clk);
      if (s_tready0) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          tests++;
          fails++;
          $error("FAIL send_timeout: observed tready=0 for %0d cycles, expected accept", n);
          done = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = 4'hF;
    m_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m0_tvalid), 64'(0));
    chk("rst_tlast",  64'(m0_tlast),  64'(0));
    chk("rst_tdata",  64'(m0_tdata),  64'(0));
    chk("rst_tstrb",  64'(m0_tstrb),  64'(0));
    chk("rst_tready", 64'(s_tready0), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 64'(s_tready0), 64'(1));
    @(posedge clk);
    #1;

    // 1: two full windows of 100, no filtering
    for (int i = 0; i < 16; i++) send(100, 1'b0);
    idle(3);
    pop0("t1_out0", 32'd100, 1'b0);
    pop0("t1_out1", 32'd100, 1'b0);
    chk("t1_count", 64'(q0.size()), 64'(0));

    // 2: cancelling samples, then the most negative full window
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 1000 : -1000, 1'b0);
    for (int i = 0; i < 8; i++) send(-32768, 1'b0);
    idle(3);
    pop0("t2_zero", 32'd0, 1'b0);
    pop0("t2_minneg", 32'h0000_8000, 1'b0);
    chk("t2_count", 64'(q0.size()), 64'(0));

    // 3: backpressure for 20 cycles with a beat waiting upstream
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(7, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = {16'h0, 16'd9};
    repeat (20) begin
      @(negedge clk);
      chk("t3_stall_tready", 64'(s_tready0), 64'(0));
      chk("t3_stall_valid",  64'(m0_tvalid), 64'(1));
      chk("t3_stall_data",   64'(m0_tdata),  64'(7));
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(9, 1'b0);
    idle(3);
    pop0("t3_held", 32'd7, 1'b0);
    pop0("t3_next", 32'd9, 1'b0);
    chk("t3_count", 64'(q0.size()), 64'(0));

    // 4: early tlast, then a fresh full window
    send(800, 1'b0);
    send(800, 1'b0);
    send(800, 1'b1);
    for (int i = 0; i < 8; i++) send(40, 1'b0);
    idle(3);
    pop0("t4_partial", 32'd300, 1'b1);
    pop0("t4_fresh", 32'd40, 1'b0);
    chk("t4_count", 64'(q0.size()), 64'(0));

    // 6: reset mid-window discards the partial sum
    for (int i = 0; i < 5; i++) send(77, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tready", 64'(s_tready0), 64'(0));
    chk("t6_rst_valid",  64'(m0_tvalid), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_valid0", 64'(m0_tvalid), 64'(0));
    chk("t6_after_valid4", 64'(m4_tvalid), 64'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(50, 1'b0);
    idle(3);
    pop0("t6_first", 32'd50, 1'b0);
    chk("t6_count", 64'(q0.size()), 64'(0));

    // 5: de-emphasis step response from y = 0
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q4.delete();
    for (int i = 0; i < 24; i++) send(1600, 1'b0);
    idle(3);
    pop4("t5_step0", 32'd100, 1'b0);
    pop4("t5_step1", 32'd193, 1'b0);
    pop4("t5_step2", 32'd281, 1'b0);
    chk("t5_count4", 64'(q4.size()), 64'(0));
    pop0("t5_bypass", 32'd1600, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
